demux_1to4_stream: RTL and testbench
====================================

// Module: demux_1to4_stream
//
// PURPOSE
// - Registered 1-to-4 demultiplexer: the distribution counterpart of mux_4to1.
// - Routes one input word stream to one of four output channels, selected by sel.
// - Each channel has a one-entry holding register with valid/ready backpressure.
// - Sits between a single producer and four independent consumers.
// - Per-channel transfer counters support debug and bench checking.
//
// PARAMETERS
// WIDTH    8   data word width in bits
// CNT_W    8   per-channel delivered-word counter width (wraps)
//
// PORTS
// clk        in   1          single clock, rising edge
// rst        in   1          asynchronous, active-high reset
// sel        in   2          destination channel, sampled only when in_valid=1
// in_valid   in   1          producer has a word on data_in
// in_ready   out  1          block accepts data_in this cycle
// data_in    in   WIDTH      input word
// out_valid  out  4          bit i: channel i holds an undelivered word
// out_ready  in   4          bit i: consumer i takes the word this cycle
// data_out   out  4*WIDTH    channel i word on [i*WIDTH +: WIDTH]
// cnt_flat   out  4*CNT_W    channel i delivered-word count on [i*CNT_W +: CNT_W]
//
// BEHAVIOUR
// - Reset (async assert, sync deassert at the next clk edge): out_valid=0, data_out=0, cnt_flat=0.
//   Reset mid-transfer discards held words; no output pulses occur after reset.
// - in_ready = ~out_valid[sel] | out_ready[sel]. It is combinational, depends on sel,
//   and does not depend on in_valid.
// - Accept = in_valid & in_ready. On an accept, at the clock edge:
//   data_out[sel] <= data_in and out_valid[sel] <= 1.
//   Latency is 1 cycle from accept to out_valid.
// - Deliver[i] = out_valid[i] & out_ready[i]. On a deliver, at the edge:
//   out_valid[i] <= 0 (unless reloaded in the same cycle) and cnt[i] <= cnt[i]+1,
//   wrapping modulo 2^CNT_W.
// - Simultaneous deliver and accept on the same channel:
//   - The old word is delivered.
//   - The new word is loaded.
//   - out_valid stays 1 and cnt increments.
//   - Full throughput is 1 word/cycle.
// - Deliveries on the other channels proceed independently in the same cycle.
//   Up to 4 counters may increment at once.
// - Channel full and consumer stalled (out_valid[sel]=1, out_ready[sel]=0):
//   - in_ready=0 and the input stalls.
//   - The held word and data_out stay stable.
//   - No word is dropped or overwritten.
// - A stall on one channel does not block the other channels.
//   Changing sel to a free channel gives in_ready=1 in the same cycle.
// - data_out[i] keeps its last value after delivery. It is only meaningful while out_valid[i]=1.
// - out_ready[i] asserted while out_valid[i]=0 has no effect and the counter does not change.
// - sel and data_in are ignored when in_valid=0.
// - Channel state per i is a 2-state FSM:
//   - EMPTY -accept(i)-> FULL
//   - FULL -deliver & !accept(i)-> EMPTY
//   - FULL -deliver & accept(i)-> FULL
//
// TESTING
// 1 Reset with in_valid=0 -> out_valid=4'b0000, data_out=0, cnt_flat=0, in_ready=1 for all sel.
// 2 sel=2, data_in=8'hA5, in_valid=1 for 1 cycle, out_ready=0 -> next cycle out_valid=4'b0100,
//   data_out ch2=8'hA5; ch0,1,3 remain 0.
// 3 With ch2 full and out_ready[2]=0, present sel=2, data_in=8'h3C -> in_ready=0, ch2 holds 8'hA5;
//   switch to sel=1 -> in_ready=1, ch1=8'h3C next cycle.
// 4 Stream 8'h01..8'h08 to sel=3 with out_ready[3]=1 every cycle -> in_ready stays 1,
//   words appear in order with 1-cycle latency, cnt ch3=8.
// 5 Assert out_ready=4'b1111 with all channels full -> all out_valid clear in one cycle,
//   each cnt increments by 1; 256 deliveries on ch0 -> cnt ch0 wraps to 0.
// 6 Assert rst asynchronously between edges while ch0 is full -> out_valid=0 immediately;
//   after release, no spurious out_valid; the first accept works normally.

Source files
------------

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: one producer, four consumers, each channel
// holding one word behind valid/ready, with wrapping per-channel delivery counters.
module demux_1to4_stream #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     data_in,
   output logic [3:0]           out_valid,
   input  logic [3:0]           out_ready,
   output logic [4*WIDTH-1:0]   data_out,
   output logic [4*CNT_W-1:0]   cnt_flat
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

   chan_state_t          state_q [4];
   chan_state_t          state_d [4];
   logic [WIDTH-1:0]     data_q  [4];
   logic [CNT_W-1:0]     cnt_q   [4];
   logic [3:0]           accept;
   logic [3:0]           deliver;

   always_comb begin
      out_valid = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         out_valid[i] = (state_q[i] == FULL);
      end
   end

   // A full channel still accepts when its consumer drains it in the same cycle.
   always_comb begin
      in_ready = ~out_valid[sel] | out_ready[sel];
   end

   always_comb begin
      accept = '0;
      if (in_valid && in_ready) begin
         accept[sel] = 1'b1;
      end
      deliver = out_valid & out_ready;
   end

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            EMPTY:   if (accept[i]) state_d[i] = FULL;
            FULL:    if (deliver[i] && !accept[i]) state_d[i] = EMPTY;
            default: state_d[i] = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 4; i++) begin
            state_q[i] <= EMPTY;
            data_q[i]  <= '0;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            if (accept[i]) begin
               data_q[i] <= data_in;
            end
            if (deliver[i]) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      data_out = '0;
      cnt_flat = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         data_out[i*WIDTH +: WIDTH] = data_q[i];
         cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Scoreboard bench for demux_1to4_stream: directed scenarios followed by random traffic,
// with per-channel expected-word queues and delivery counts held in the bench.
module tb_demux_1to4_stream;

   localparam int WIDTH = 8;
   localparam int CNT_W = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [1:0]           sel;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     data_in;
   logic [3:0]           out_valid;
   logic [3:0]           out_ready;
   logic [4*WIDTH-1:0]   data_out;
   logic [4*CNT_W-1:0]   cnt_flat;

   demux_1to4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .cnt_flat(cnt_flat)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: words issued to each channel and not yet taken, oldest first.
   logic [WIDTH-1:0] exp_q [4][$];
   logic [CNT_W-1:0] cnt_m [4];
   bit               pend_v;
   int               pend_ch;
   bit               chk_en;
   int               held [4];

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs just after the edge; issued words enter the scoreboard now.
   task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] r);
      @(posedge clk); #1;
      in_valid = v; sel = s; data_in = d; out_ready = r;
      pend_v = 1'b0;
      if (v && (exp_q[s].size() == 0 || r[s])) begin
         exp_q[s].push_back(d);
         pend_v  = 1'b1;
         pend_ch = int'(s);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         exp_q[i].delete();
         cnt_m[i] = '0;
      end
      pend_v = 1'b0;
   endtask

   // Monitor: outputs are stable at the falling edge, inputs already set for the next edge.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         for (int i = 0; i < 4; i++) begin
            held[i] = exp_q[i].size() - ((pend_v && pend_ch == i) ? 1 : 0);
         end
         chk("in_ready", in_ready, (held[sel] == 0) || out_ready[sel]);
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("out_valid[%0d]", i), out_valid[i], held[i] > 0);
            chk($sformatf("cnt[%0d]", i), cnt_flat[i*CNT_W +: CNT_W], cnt_m[i]);
            if (held[i] > 0) begin
               chk($sformatf("data_out[%0d]", i), data_out[i*WIDTH +: WIDTH], exp_q[i][0]);
               if (out_ready[i]) begin
                  void'(exp_q[i].pop_front());
                  cnt_m[i] = cnt_m[i] + 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      chk_en = 1'b0;
      rst = 1'b1; in_valid = 1'b0; sel = '0; data_in = '0; out_ready = '0;
      model_clear();
      #12;
      chk("rst out_valid", out_valid, 4'b0000);
      chk("rst data_out", data_out, 0);
      chk("rst cnt_flat", cnt_flat, 0);
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s); #1;
         chk($sformatf("rst in_ready sel%0d", s), in_ready, 1);
      end
      sel = '0;
      @(negedge clk); rst = 1'b0;
      chk_en = 1'b1;

      // Single word to channel 2
      step(1'b1, 2'd2, 8'hA5, 4'b0000);
      step(1'b0, 2'd0, 8'h00, 4'b0000);
      chk("t2 out_valid", out_valid, 4'b0100);
      chk("t2 data_out", data_out, 32'h00A5_0000);

      // Stall on full ch2, then redirect to ch1
      step(1'b1, 2'd2, 8'h3C, 4'b0000); #1;
      chk("t3 in_ready stalled", in_ready, 0);
      step(1'b1, 2'd1, 8'h3C, 4'b0000); #1;
      chk("t3 in_ready free", in_ready, 1);
      step(1'b0, 2'd0, 8'h00, 4'b0000);
      chk("t3 out_valid", out_valid, 4'b0110);
      chk("t3 ch1", data_out[15:8], 8'h3C);
      chk("t3 ch2 held", data_out[23:16], 8'hA5);

      // Full-rate stream on ch3
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 2'd3, 8'(k), 4'b1000); #1;
         chk($sformatf("t4 in_ready w%0d", k), in_ready, 1);
      end
      step(1'b0, 2'd0, 8'h00, 4'b1000);
      step(1'b0, 2'd0, 8'h00, 4'b0000);
      chk("t4 cnt ch3", cnt_flat[31:24], 8);

      // All four full, drained in one cycle
      step(1'b1, 2'd0, 8'h11, 4'b0000);
      step(1'b1, 2'd3, 8'h33, 4'b0000);
      step(1'b0, 2'd0, 8'h00, 4'b1111);
      chk("t5 all full", out_valid, 4'b1111);
      step(1'b0, 2'd0, 8'h00, 4'b0000);
      chk("t5 all drained", out_valid, 4'b0000);
      chk("t5 counts", cnt_flat, 32'h0901_0101);

      // 255 more deliveries on ch0 wrap its counter
      for (int k = 0; k < 255; k++) begin
         step(1'b1, 2'd0, 8'($urandom), 4'b0001);
      end
      step(1'b0, 2'd0, 8'h00, 4'b0001);
      step(1'b0, 2'd0, 8'h00, 4'b0000);
      chk("t5 ch0 wrap", cnt_flat[7:0], 0);
      chk("t5 ch1 unchanged", cnt_flat[15:8], 1);

      // Asynchronous reset while ch0 is full
      step(1'b1, 2'd0, 8'h55, 4'b0000);
      step(1'b0, 2'd0, 8'h00, 4'b0000);
      chk("t6 ch0 full", out_valid, 4'b0001);
      chk_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t6 async out_valid", out_valid, 4'b0000);
      chk("t6 async data_out", data_out, 0);
      chk("t6 async cnt", cnt_flat, 0);
      model_clear();
      @(negedge clk); #2 rst = 1'b0;
      chk_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 2'd0, 8'h00, 4'b1111);
         chk("t6 no spurious", out_valid, 4'b0000);
      end
      step(1'b1, 2'd0, 8'hC3, 4'b0000);
      step(1'b0, 2'd0, 8'h00, 4'b0000);
      chk("t6 first accept", out_valid, 4'b0001);
      chk("t6 first data", data_out[7:0], 8'hC3);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom), 4'($urandom));
      end
      step(1'b0, 2'd0, 8'h00, 4'b1111);
      step(1'b0, 2'd0, 8'h00, 4'b1111);
      step(1'b0, 2'd0, 8'h00, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drained q%0d", i), exp_q[i].size(), 0);
      end
      @(negedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
